// File: rtl/connect4_pkg.sv
// -----------------------------------------------------------------------------
// connect4_pkg
// Shared constants and types for the Connect-4 game controller:
//   board geometry, win length, move limit, cell/winner encodings,
//   controller state encoding, line-direction deltas and small helpers.
// -----------------------------------------------------------------------------
package connect4_pkg;

  localparam int ROWS      = 6;
  localparam int COLS      = 7;
  localparam int WIN_LEN   = 4;
  localparam int MAX_MOVES = 42;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  // Winner codes for a player win reuse that player's cell code.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SCAN      = 3'd1,
    S_PLACE     = 3'd2,
    S_CHECK     = 3'd3,
    S_NEXT_TURN = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  // Direction indices, in the order the line checker walks them.
  localparam logic [1:0] DIR_H = 2'd0;  // (0,+1)
  localparam logic [1:0] DIR_V = 2'd1;  // (+1,0)
  localparam logic [1:0] DIR_D = 2'd2;  // (+1,+1)
  localparam logic [1:0] DIR_A = 2'd3;  // (+1,-1)

  // Row delta of a direction.
  function automatic logic signed [3:0] dir_dr(input logic [1:0] d);
    case (d)
      DIR_H:   return 4'sd0;
      DIR_V:   return 4'sd1;
      DIR_D:   return 4'sd1;
      DIR_A:   return 4'sd1;
      default: return 4'sd0;
    endcase
  endfunction

  // Column delta of a direction.
  function automatic logic signed [3:0] dir_dc(input logic [1:0] d);
    case (d)
      DIR_H:   return 4'sd1;
      DIR_V:   return 4'sd0;
      DIR_D:   return 4'sd1;
      DIR_A:   return -4'sd1;
      default: return 4'sd0;
    endcase
  endfunction

  // The player whose turn follows p.
  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/c4_line_checker.sv
// -----------------------------------------------------------------------------
// c4_line_checker
// Sequential win detector for the piece just placed at (row_i, col_i).
// Walks the four line directions one cell per cycle, counting contiguous
// cells owned by player_i on both sides of the origin.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   abort_i     abandon any walk in progress
//   start_i     one-cycle pulse: latch origin and player, begin walking
//   grid_i      board contents (row-major, row 0 on top)
//   row_i/col_i origin of the newly placed piece
//   player_i    owner of the newly placed piece
//   done_o      one-cycle pulse when the walk has finished
//   win_o       valid with done_o: a line of WIN_LEN was found
// -----------------------------------------------------------------------------
module c4_line_checker
  import connect4_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          abort_i,
  input  logic                          start_i,
  input  logic [0:ROWS-1][0:COLS-1][1:0] grid_i,
  input  logic [2:0]                    row_i,
  input  logic [2:0]                    col_i,
  input  logic [1:0]                    player_i,
  output logic                          done_o,
  output logic                          win_o
);

  logic              run_q;
  logic [1:0]        dir_q;
  logic              neg_q;     // 0: walking the + sense, 1: the - sense
  logic [1:0]        steps_q;
  logic [2:0]        count_q;
  logic signed [3:0] pr_q, pc_q;  // current walk position
  logic signed [3:0] or_q, oc_q;  // latched origin
  logic [1:0]        ply_q;
  logic              done_q, win_q;

  logic signed [3:0] dr_s, dc_s, nr_s, nc_s;
  logic              inb_s, match_s;
  logic [2:0]        ri_s, ci_s;

  // Next cell of the walk, its bounds test and whether it extends the line.
  always_comb begin
    dr_s = dir_dr(dir_q);
    dc_s = dir_dc(dir_q);
    if (neg_q) begin
      nr_s = pr_q - dr_s;
      nc_s = pc_q - dc_s;
    end else begin
      nr_s = pr_q + dr_s;
      nc_s = pc_q + dc_s;
    end
    // Signed compare catches a step to -1 before it can alias to index 7.
    inb_s = (nr_s >= 4'sd0) && (nr_s < $signed(4'(ROWS))) &&
            (nc_s >= 4'sd0) && (nc_s < $signed(4'(COLS)));
    if (inb_s) begin
      ri_s = nr_s[2:0];
      ci_s = nc_s[2:0];
    end else begin
      ri_s = 3'd0;
      ci_s = 3'd0;
    end
    match_s = inb_s && (grid_i[ri_s][ci_s] == ply_q) && (steps_q < 2'd3);
  end

  // Walk sequencer: + sense then - sense per direction, early exit on a win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      dir_q   <= DIR_H;
      neg_q   <= 1'b0;
      steps_q <= 2'd0;
      count_q <= 3'd1;
      pr_q    <= 4'sd0;
      pc_q    <= 4'sd0;
      or_q    <= 4'sd0;
      oc_q    <= 4'sd0;
      ply_q   <= EMPTY;
      done_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      win_q  <= 1'b0;
      if (abort_i) begin
        run_q <= 1'b0;
      end else if (start_i) begin
        run_q   <= 1'b1;
        dir_q   <= DIR_H;
        neg_q   <= 1'b0;
        steps_q <= 2'd0;
        count_q <= 3'd1;
        pr_q    <= $signed({1'b0, row_i});
        pc_q    <= $signed({1'b0, col_i});
        or_q    <= $signed({1'b0, row_i});
        oc_q    <= $signed({1'b0, col_i});
        ply_q   <= player_i;
      end else if (run_q) begin
        if (match_s) begin
          count_q <= count_q + 3'd1;
          steps_q <= steps_q + 2'd1;
          pr_q    <= nr_s;
          pc_q    <= nc_s;
          if ((count_q + 3'd1) >= 3'(WIN_LEN)) begin
            run_q  <= 1'b0;
            done_q <= 1'b1;
            win_q  <= 1'b1;
          end
        end else if (!neg_q) begin
          neg_q   <= 1'b1;
          steps_q <= 2'd0;
          pr_q    <= or_q;
          pc_q    <= oc_q;
        end else if (dir_q == DIR_A) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end else begin
          dir_q   <= dir_q + 2'd1;
          neg_q   <= 1'b0;
          steps_q <= 2'd0;
          count_q <= 3'd1;
          pr_q    <= or_q;
          pc_q    <= oc_q;
        end
      end
    end
  end

  assign done_o = done_q;
  assign win_o  = win_q;

endmodule

// File: rtl/connect4_game_ctrl.sv
// -----------------------------------------------------------------------------
// connect4_game_ctrl
// Game sequencer owning the 6x7 board shown by the renderer.
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   move_left     pulse: cursor one column left (saturating)
//   move_right    pulse: cursor one column right (saturating)
//   drop          pulse: drop the current player's piece in the cursor column
//   new_game      pulse: clear board and restart (overrides everything)
//   grid          registered board, 00 empty / 01 P1 / 10 P2
//   cursor_col    selected column 0..6
//   cur_player    player to move, 01 or 10
//   busy          a move is being processed
//   game_over     game finished, board frozen
//   winner        00 none, 01 P1, 10 P2, 11 draw
//   invalid_move  one-cycle pulse: drop into a full column rejected
// -----------------------------------------------------------------------------
module connect4_game_ctrl
  import connect4_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          move_left,
  input  logic                          move_right,
  input  logic                          drop,
  input  logic                          new_game,
  output logic [0:ROWS-1][0:COLS-1][1:0] grid,
  output logic [2:0]                    cursor_col,
  output logic [1:0]                    cur_player,
  output logic                          busy,
  output logic                          game_over,
  output logic [1:0]                    winner,
  output logic                          invalid_move
);

  state_t                        state_q;
  logic [0:ROWS-1][0:COLS-1][1:0] grid_q;
  logic [2:0]                    cursor_q;
  logic [1:0]                    player_q;
  logic [5:0]                    move_cnt_q;
  logic [1:0]                    winner_q;
  logic                          invalid_q;
  logic                          busy_q;
  logic                          game_over_q;
  logic [2:0]                    row_q;
  logic [2:0]                    col_q;
  logic                          chk_start_q;

  logic chk_done_s, chk_win_s;

  c4_line_checker u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort_i  (new_game),
    .start_i  (chk_start_q),
    .grid_i   (grid_q),
    .row_i    (row_q),
    .col_i    (col_q),
    .player_i (player_q),
    .done_o   (chk_done_s),
    .win_o    (chk_win_s)
  );

  // Game FSM, cursor and board with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grid_q      <= '0;
      cursor_q    <= 3'd3;
      player_q    <= P1;
      move_cnt_q  <= 6'd0;
      winner_q    <= WIN_NONE;
      invalid_q   <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      chk_start_q <= 1'b0;
    end else if (new_game) begin
      state_q     <= S_IDLE;
      grid_q      <= '0;
      cursor_q    <= 3'd3;
      player_q    <= P1;
      move_cnt_q  <= 6'd0;
      winner_q    <= WIN_NONE;
      invalid_q   <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      chk_start_q <= 1'b0;
    end else begin
      invalid_q   <= 1'b0;
      chk_start_q <= 1'b0;

      // Simultaneous left+right cancels; both ends saturate.
      if (state_q != S_GAME_OVER) begin
        if (move_left && !move_right && (cursor_q != 3'd0)) begin
          cursor_q <= cursor_q - 3'd1;
        end else if (move_right && !move_left && (cursor_q != 3'(COLS-1))) begin
          cursor_q <= cursor_q + 3'd1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (drop) begin
            col_q <= cursor_q;
            if (grid_q[0][cursor_q] != EMPTY) begin
              invalid_q <= 1'b1;
            end else begin
              row_q   <= 3'(ROWS-1);
              state_q <= S_SCAN;
              busy_q  <= 1'b1;
            end
          end
        end
        // Top row is known empty, so the upward scan always terminates.
        S_SCAN: begin
          if (grid_q[row_q][col_q] == EMPTY) begin
            state_q <= S_PLACE;
          end else begin
            row_q <= row_q - 3'd1;
          end
        end
        S_PLACE: begin
          grid_q[row_q][col_q] <= player_q;
          move_cnt_q           <= move_cnt_q + 6'd1;
          chk_start_q          <= 1'b1;
          state_q              <= S_CHECK;
        end
        S_CHECK: begin
          if (chk_done_s) begin
            if (chk_win_s) begin
              winner_q    <= player_q;
              state_q     <= S_GAME_OVER;
              busy_q      <= 1'b0;
              game_over_q <= 1'b1;
            end else begin
              state_q <= S_NEXT_TURN;
            end
          end
        end
        S_NEXT_TURN: begin
          busy_q <= 1'b0;
          if (move_cnt_q == 6'(MAX_MOVES)) begin
            winner_q    <= WIN_DRAW;
            state_q     <= S_GAME_OVER;
            game_over_q <= 1'b1;
          end else begin
            player_q <= other_player(player_q);
            state_q  <= S_IDLE;
          end
        end
        S_GAME_OVER: begin
          state_q <= S_GAME_OVER;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign grid         = grid_q;
  assign cursor_col   = cursor_q;
  assign cur_player   = player_q;
  assign busy         = busy_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;
  assign invalid_move = invalid_q;

endmodule

// File: tb/tb_connect4_game_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for connect4_game_ctrl. A behavioural board model
// predicts each drop's outcome (landing cell, brute-force line search,
// draw at 42 moves); predictions are queued when the drop is driven and
// compared once the controller goes idle. Cursor behaviour is table-driven.
// -----------------------------------------------------------------------------
module tb_connect4_game_ctrl;

  logic                   clk;
  logic                   rst_n;
  logic                   move_left, move_right, drop, new_game;
  logic [0:5][0:6][1:0]   grid;
  logic [2:0]             cursor_col;
  logic [1:0]             cur_player;
  logic                   busy, game_over;
  logic [1:0]             winner;
  logic                   invalid_move;

  connect4_game_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .move_left    (move_left),
    .move_right   (move_right),
    .drop         (drop),
    .new_game     (new_game),
    .grid         (grid),
    .cursor_col   (cursor_col),
    .cur_player   (cur_player),
    .busy         (busy),
    .game_over    (game_over),
    .winner       (winner),
    .invalid_move (invalid_move)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [0:5][0:6][1:0] grid;
    logic [1:0]           player;
    logic [1:0]           winner;
    bit                   go;
    bit                   invalid;
    bit                   ignored;
  } exp_t;

  typedef struct packed {
    logic       l;
    logic       r;
    logic [2:0] exp_col;
  } cur_vec_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [0:5][0:6][1:0] mboard;
  logic [1:0]           m_player;
  logic [1:0]           m_winner;
  bit                   m_go;
  int                   m_cursor;
  int                   m_moves;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_grid(input string name, input logic [0:5][0:6][1:0] act,
                          input logic [0:5][0:6][1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mboard   = '0;
    m_player = 2'b01;
    m_winner = 2'b00;
    m_go     = 1'b0;
    m_cursor = 3;
    m_moves  = 0;
  endtask

  // Brute-force search of every 4-cell window in the four line directions.
  function automatic bit has_win(input logic [0:5][0:6][1:0] b, input logic [1:0] p);
    int dr [4];
    int dc [4];
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 7; c++) begin
          bit ok;
          ok = 1'b1;
          for (int k = 0; k < 4; k++) begin
            int rr, cc;
            rr = r + k * dr[d];
            cc = c + k * dc[d];
            if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
            else if (b[rr][cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic check_state(input string tag);
    chk_grid({tag, "_grid"}, grid, mboard);
    chk({tag, "_cursor"}, int'(cursor_col), m_cursor);
    chk({tag, "_player"}, int'(cur_player), int'(m_player));
    chk({tag, "_winner"}, int'(winner), int'(m_winner));
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_game_over"}, int'(game_over), int'(m_go));
    chk({tag, "_invalid"}, int'(invalid_move), 0);
  endtask

  task automatic move_cursor(input int col);
    while (m_cursor != col) begin
      if (m_cursor > col) begin
        move_left = 1'b1;
        m_cursor--;
      end else begin
        move_right = 1'b1;
        m_cursor++;
      end
      tick();
      move_left  = 1'b0;
      move_right = 1'b0;
    end
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_reset();
  endtask

  // Drop in col: predict, queue the prediction, drive, wait, compare.
  task automatic play(input int col);
    exp_t e, got;
    int   r, cyc;
    if (!m_go) move_cursor(col);
    chk("drop_cursor", int'(cursor_col), m_cursor);
    e.invalid = 1'b0;
    e.ignored = 1'b0;
    if (m_go) begin
      e.ignored = 1'b1;
    end else if (mboard[0][col] != 2'b00) begin
      e.invalid = 1'b1;
    end else begin
      r = 5;
      while (mboard[r][col] != 2'b00) r--;
      mboard[r][col] = m_player;
      m_moves++;
      if (has_win(mboard, m_player)) begin
        m_winner = m_player;
        m_go     = 1'b1;
      end else if (m_moves == 42) begin
        m_winner = 2'b11;
        m_go     = 1'b1;
      end else begin
        m_player = (m_player == 2'b01) ? 2'b10 : 2'b01;
      end
    end
    e.grid   = mboard;
    e.player = m_player;
    e.winner = m_winner;
    e.go     = m_go;
    sb.push_back(e);

    drop = 1'b1;
    tick();
    drop = 1'b0;
    if (e.invalid || e.ignored) begin
      chk("invalid_pulse", int'(invalid_move), int'(e.invalid));
      chk("busy_after_reject", int'(busy), 0);
      tick();
      chk("invalid_one_cycle", int'(invalid_move), 0);
    end else begin
      cyc = 0;
      while (busy !== 1'b0 && cyc < 64) begin
        tick();
        cyc++;
      end
      if (cyc >= 64) begin
        checks++;
        errors++;
        $display("FAIL busy_timeout: got busy=%0b after 64 cycles expected 0", busy);
      end
    end

    got = sb.pop_front();
    chk_grid("move_grid", grid, got.grid);
    chk("move_player", int'(cur_player), int'(got.player));
    chk("move_winner", int'(winner), int'(got.winner));
    chk("move_game_over", int'(game_over), int'(got.go));
  endtask

  initial begin
    cur_vec_t cv [17];
    int       ca [3];
    int       cb [3];

    cv = '{
      '{1'b1, 1'b0, 3'd2}, '{1'b1, 1'b0, 3'd1}, '{1'b1, 1'b0, 3'd0},
      '{1'b1, 1'b0, 3'd0}, '{1'b1, 1'b0, 3'd0},
      '{1'b0, 1'b1, 3'd1}, '{1'b0, 1'b1, 3'd2}, '{1'b0, 1'b1, 3'd3},
      '{1'b0, 1'b1, 3'd4}, '{1'b0, 1'b1, 3'd5}, '{1'b0, 1'b1, 3'd6},
      '{1'b0, 1'b1, 3'd6}, '{1'b0, 1'b1, 3'd6}, '{1'b0, 1'b1, 3'd6},
      '{1'b1, 1'b1, 3'd6}, '{1'b1, 1'b0, 3'd5}, '{1'b1, 1'b1, 3'd5}
    };
    ca = '{0, 1, 4};
    cb = '{2, 3, 6};

    rst_n = 1'b0; move_left = 1'b0; move_right = 1'b0; drop = 1'b0; new_game = 1'b0;
    model_reset();
    #22;
    check_state("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Two drops in the centre column
    play(3);
    play(3);
    chk("first_piece", int'(grid[5][3]), 1);
    chk("second_piece", int'(grid[4][3]), 2);
    chk("player_back_p1", int'(cur_player), 1);

    // Cursor table
    for (int i = 0; i < 17; i++) begin
      move_left  = cv[i].l;
      move_right = cv[i].r;
      tick();
      move_left  = 1'b0;
      move_right = 1'b0;
      chk($sformatf("cursor_vec%0d", i), int'(cursor_col), int'(cv[i].exp_col));
    end
    m_cursor = 5;

    // new_game together with drop: drop ignored, everything cleared
    new_game = 1'b1;
    drop     = 1'b1;
    tick();
    new_game = 1'b0;
    drop     = 1'b0;
    model_reset();
    check_state("newgame_drop");

    // Full column
    for (int i = 0; i < 7; i++) play(2);
    chk("full_col_player", int'(cur_player), 1);

    // Horizontal P1 win on the bottom row
    pulse_new_game();
    play(0); play(0); play(1); play(1); play(2); play(2); play(3);
    chk("hwin_winner", int'(winner), 1);
    chk("hwin_game_over", int'(game_over), 1);
    move_left = 1'b1;
    tick();
    move_left = 1'b0;
    chk("gameover_cursor_frozen", int'(cursor_col), 3);
    play(5);

    // Anti-diagonal P2 win completed at the bottom-left corner
    pulse_new_game();
    play(3); play(3); play(3); play(3); play(2); play(6);
    play(2); play(2); play(1); play(1); play(6); play(0);
    chk("adiag_winner", int'(winner), 2);
    chk("adiag_corner", int'(grid[5][0]), 2);

    // 42-move draw: columns paired so no line of four ever forms
    pulse_new_game();
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 12; k++) begin
        play(((k % 4) == 1 || (k % 4) == 2) ? cb[p] : ca[p]);
      end
    end
    for (int k = 0; k < 6; k++) play(5);
    chk("draw_winner", int'(winner), 3);
    chk("draw_game_over", int'(game_over), 1);

    // new_game while the line checker is running
    pulse_new_game();
    move_cursor(5);
    drop = 1'b1;
    tick();
    drop = 1'b0;
    tick();
    tick();
    chk("placed_before_abort", int'(grid[5][5]), 1);
    chk("busy_in_check", int'(busy), 1);
    tick();
    pulse_new_game();
    check_state("abort_check");

    // Asynchronous reset during a multi-row scan
    play(4); play(4); play(4);
    drop = 1'b1;
    tick();
    drop = 1'b0;
    tick();
    chk("busy_in_scan", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_state("after_reset");

    // Normal play resumes
    play(3);
    chk("resume_piece", int'(grid[5][3]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
